// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file's single write port: pipeline write-back vs. a buffered
// long-unit result with a starvation bound. Optional RAW scoreboard enabled by WB_SCOREBOARD_EN.
module regfile_wb_arbiter #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pipe_we,
  input  logic [ADDRESS_WIDTH-1:0] pipe_rd,
  input  logic [DATA_WIDTH-1:0]    pipe_wd,
  output logic                     pipe_stall,
  input  logic                     lu_valid,
  output logic                     lu_ready,
  input  logic [ADDRESS_WIDTH-1:0] lu_rd,
  input  logic [DATA_WIDTH-1:0]    lu_wd,
  input  logic                     issue_valid,
  input  logic [ADDRESS_WIDTH-1:0] issue_rd,
  input  logic [ADDRESS_WIDTH-1:0] rs1,
  input  logic [ADDRESS_WIDTH-1:0] rs2,
  output logic                     hazard,
  output logic                     rf_we,
  output logic [ADDRESS_WIDTH-1:0] rf_ad,
  output logic [DATA_WIDTH-1:0]    rf_wd
);

  localparam int DEPTH = 1 << ADDRESS_WIDTH;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic                     buf_full_q, buf_full_d;
  logic [ADDRESS_WIDTH-1:0] buf_rd_q, buf_rd_d;
  logic [DATA_WIDTH-1:0]    buf_wd_q, buf_wd_d;
  logic [CNT_W-1:0]         starve_cnt_q, starve_cnt_d;
  logic                     rf_we_q, rf_we_d;
  logic [ADDRESS_WIDTH-1:0] rf_ad_q, rf_ad_d;
  logic [DATA_WIDTH-1:0]    rf_wd_q, rf_wd_d;
  logic                     out_lu_q, out_lu_d;
  logic                     force_s;
  logic                     buf_win_s;
  logic                     accept_s;

  assign force_s    = buf_full_q && (starve_cnt_q == LIMIT);
  assign buf_win_s  = force_s || (buf_full_q && !pipe_we);
  assign lu_ready   = !buf_full_q && !rst;
  assign accept_s   = lu_valid && lu_ready;
  assign pipe_stall = force_s && !rst;

  // Grant selection, buffer bookkeeping and next output-stage contents.
  always_comb begin
    rf_we_d      = 1'b0;
    rf_ad_d      = rf_ad_q;
    rf_wd_d      = rf_wd_q;
    out_lu_d     = 1'b0;
    starve_cnt_d = starve_cnt_q;
    if (buf_win_s) begin
      rf_we_d      = (buf_rd_q != {ADDRESS_WIDTH{1'b0}});
      rf_ad_d      = buf_rd_q;
      rf_wd_d      = buf_wd_q;
      out_lu_d     = 1'b1;
      starve_cnt_d = {CNT_W{1'b0}};
    end else if (pipe_we) begin
      rf_we_d  = (pipe_rd != {ADDRESS_WIDTH{1'b0}});
      rf_ad_d  = pipe_rd;
      rf_wd_d  = pipe_wd;
      out_lu_d = 1'b0;
      // Counter cannot pass LIMIT: reaching it forces a buffer win next cycle.
      if (buf_full_q) begin
        starve_cnt_d = starve_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        starve_cnt_d = starve_cnt_q;
      end
    end else begin
      rf_we_d = 1'b0;
    end

    if (buf_win_s) begin
      buf_full_d = 1'b0;
      buf_rd_d   = buf_rd_q;
      buf_wd_d   = buf_wd_q;
    end else if (accept_s) begin
      buf_full_d = 1'b1;
      buf_rd_d   = lu_rd;
      buf_wd_d   = lu_wd;
    end else begin
      buf_full_d = buf_full_q;
      buf_rd_d   = buf_rd_q;
      buf_wd_d   = buf_wd_q;
    end
  end

  // Arbiter state and registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_full_q   <= 1'b0;
      buf_rd_q     <= {ADDRESS_WIDTH{1'b0}};
      buf_wd_q     <= {DATA_WIDTH{1'b0}};
      starve_cnt_q <= {CNT_W{1'b0}};
      rf_we_q      <= 1'b0;
      rf_ad_q      <= {ADDRESS_WIDTH{1'b0}};
      rf_wd_q      <= {DATA_WIDTH{1'b0}};
      out_lu_q     <= 1'b0;
    end else begin
      buf_full_q   <= buf_full_d;
      buf_rd_q     <= buf_rd_d;
      buf_wd_q     <= buf_wd_d;
      starve_cnt_q <= starve_cnt_d;
      rf_we_q      <= rf_we_d;
      rf_ad_q      <= rf_ad_d;
      rf_wd_q      <= rf_wd_d;
      out_lu_q     <= out_lu_d;
    end
  end

  assign rf_we = rf_we_q;
  assign rf_ad = rf_ad_q;
  assign rf_wd = rf_wd_q;

`ifdef WB_SCOREBOARD_EN
  logic [DEPTH-1:0] busy_q, busy_d;

  // Pending long-unit destinations; a same-cycle set overrides the clear.
  always_comb begin
    busy_d = busy_q;
    if (rf_we_q && out_lu_q) begin
      busy_d[rf_ad_q] = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (issue_valid && (issue_rd != {ADDRESS_WIDTH{1'b0}})) begin
      busy_d[issue_rd] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
  end

  // Scoreboard storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= {DEPTH{1'b0}};
    end else begin
      busy_q <= busy_d;
    end
  end

  assign hazard = ((rs1 != {ADDRESS_WIDTH{1'b0}}) && busy_q[rs1]) ||
                  ((rs2 != {ADDRESS_WIDTH{1'b0}}) && busy_q[rs2]);
`else
  logic unused_s;
  assign unused_s = ^{issue_valid, issue_rd, rs1, rs2, DEPTH[0]};
  assign hazard   = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, hand sequences and random traffic
// checked against a queue-based reference model.
module tb_regfile_wb_arbiter;
  localparam int AW  = 5;
  localparam int DW  = 32;
  localparam int LIM = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, pipe_we, pipe_stall, lu_valid, lu_ready, issue_valid, hazard, rf_we;
  logic [AW-1:0] pipe_rd, lu_rd, issue_rd, rs1, rs2, rf_ad;
  logic [DW-1:0] pipe_wd, lu_wd, rf_wd;

  regfile_wb_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst), .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_wd(pipe_wd),
    .pipe_stall(pipe_stall), .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd),
    .lu_wd(lu_wd), .issue_valid(issue_valid), .issue_rd(issue_rd), .rs1(rs1), .rs2(rs2),
    .hazard(hazard), .rf_we(rf_we), .rf_ad(rf_ad), .rf_wd(rf_wd)
  );

  typedef struct packed {
    logic          rst;
    logic          pipe_we;
    logic [AW-1:0] pipe_rd;
    logic [DW-1:0] pipe_wd;
    logic          lu_valid;
    logic [AW-1:0] lu_rd;
    logic [DW-1:0] lu_wd;
    logic          issue_valid;
    logic [AW-1:0] issue_rd;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
  } in_t;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] wd;
  } ent_t;

  typedef struct {
    in_t           in;
    bit            we;
    logic [AW-1:0] ad;
    logic [DW-1:0] wd;
    bit            stall;
    bit            ready;
  } row_t;

  int checks = 0;
  int errors = 0;

  // Reference model: pending long-unit results, wait counter, expected write port, busy set.
  ent_t          m_buf[$];
  int            m_wait;
  bit            m_we;
  logic [AW-1:0] m_ad;
  logic [DW-1:0] m_wd;
  bit            m_lu;
  bit            m_busy[32];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic in_t mk(input bit r, input bit pwe, input int prd, input int pwd,
                             input bit luv, input int lrd, input int lwd);
    in_t v;
    v = '0;
    v.rst = r; v.pipe_we = pwe; v.pipe_rd = AW'(prd); v.pipe_wd = DW'(pwd);
    v.lu_valid = luv; v.lu_rd = AW'(lrd); v.lu_wd = DW'(lwd);
    return v;
  endfunction

  task automatic apply(input in_t v);
    rst = v.rst; pipe_we = v.pipe_we; pipe_rd = v.pipe_rd; pipe_wd = v.pipe_wd;
    lu_valid = v.lu_valid; lu_rd = v.lu_rd; lu_wd = v.lu_wd;
    issue_valid = v.issue_valid; issue_rd = v.issue_rd; rs1 = v.rs1; rs2 = v.rs2;
    #1;
  endtask

  task automatic compare_model(input in_t v);
    bit exp_hz;
    exp_hz = 1'b0;
`ifdef WB_SCOREBOARD_EN
    exp_hz = (v.rs1 != 0 && m_busy[v.rs1]) || (v.rs2 != 0 && m_busy[v.rs2]);
`endif
    chk("model_rf_we", 64'(rf_we), 64'(m_we));
    chk("model_rf_ad", 64'(rf_ad), 64'(m_ad));
    chk("model_rf_wd", 64'(rf_wd), 64'(m_wd));
    chk("model_stall", 64'(pipe_stall),
        64'(!v.rst && m_buf.size() == 1 && m_wait == LIM));
    chk("model_ready", 64'(lu_ready), 64'(!v.rst && m_buf.size() == 0));
    chk("model_hazard", 64'(hazard), 64'(exp_hz));
  endtask

  task automatic advance(input in_t v);
    bit   take_buf, acc;
    ent_t e;
    @(posedge clk);
    if (v.rst) begin
      m_buf.delete(); m_wait = 0; m_we = 0; m_ad = '0; m_wd = '0; m_lu = 0;
      foreach (m_busy[i]) m_busy[i] = 0;
    end else begin
      acc = v.lu_valid && m_buf.size() == 0;
      if (m_we && m_lu) m_busy[m_ad] = 0;
      if (v.issue_valid && v.issue_rd != 0) m_busy[v.issue_rd] = 1;
      take_buf = m_buf.size() == 1 && (m_wait == LIM || !v.pipe_we);
      if (take_buf) begin
        e = m_buf.pop_front();
        m_we = e.rd != 0; m_ad = e.rd; m_wd = e.wd; m_lu = 1; m_wait = 0;
      end else if (v.pipe_we) begin
        m_we = v.pipe_rd != 0; m_ad = v.pipe_rd; m_wd = v.pipe_wd; m_lu = 0;
        if (m_buf.size() == 1) m_wait++;
      end else begin
        m_we = 0; m_lu = 0;
      end
      if (acc) m_buf.push_back('{rd: v.lu_rd, wd: v.lu_wd});
    end
    @(negedge clk);
  endtask

  task automatic step(input in_t v);
    apply(v);
    compare_model(v);
    advance(v);
  endtask

  row_t tbl[17];
  in_t  v;

  initial begin
    // Directed table: inputs for the cycle, outputs sampled in that same cycle.
    tbl[0]  = '{mk(1, 1, 5, 32'h1, 1, 6, 32'h2),   0, 0, 0, 0, 0};
    tbl[1]  = '{mk(0, 0, 0, 0, 0, 0, 0),           0, 0, 0, 0, 1};
    tbl[2]  = '{mk(0, 1, 5, 32'hDEADBEEF, 0, 0, 0), 0, 0, 0, 0, 1};
    tbl[3]  = '{mk(0, 1, 0, 32'h1234, 0, 0, 0),     1, 5, 32'hDEADBEEF, 0, 1};
    tbl[4]  = '{mk(0, 0, 0, 0, 1, 7, 32'h11),       0, 0, 0, 0, 1};
    tbl[5]  = '{mk(0, 1, 1, 32'hA1, 0, 0, 0),       0, 0, 0, 0, 0};
    tbl[6]  = '{mk(0, 1, 2, 32'hA2, 0, 0, 0),       1, 1, 32'hA1, 0, 0};
    tbl[7]  = '{mk(0, 1, 3, 32'hA3, 0, 0, 0),       1, 2, 32'hA2, 0, 0};
    tbl[8]  = '{mk(0, 1, 4, 32'hA4, 0, 0, 0),       1, 3, 32'hA3, 0, 0};
    tbl[9]  = '{mk(0, 1, 5, 32'hA5, 0, 0, 0),       1, 4, 32'hA4, 1, 0};
    tbl[10] = '{mk(0, 1, 6, 32'hA6, 0, 0, 0),       1, 7, 32'h11, 0, 1};
    tbl[11] = '{mk(0, 0, 0, 0, 1, 3, 32'h33),       1, 6, 32'hA6, 0, 1};
    tbl[12] = '{mk(0, 0, 0, 0, 0, 0, 0),            0, 0, 0, 0, 0};
    tbl[13] = '{mk(0, 0, 0, 0, 0, 0, 0),            1, 3, 32'h33, 0, 1};
    tbl[14] = '{mk(0, 0, 0, 0, 1, 0, 32'h55),       0, 0, 0, 0, 1};
    tbl[15] = '{mk(0, 0, 0, 0, 0, 0, 0),            0, 0, 0, 0, 0};
    tbl[16] = '{mk(0, 0, 0, 0, 0, 0, 0),            0, 0, 0, 0, 1};

    @(negedge clk);
    v = mk(1, 1, 5, 32'h1, 1, 6, 32'h2);
    apply(v);
    advance(v);

    for (int i = 0; i < 17; i++) begin
      apply(tbl[i].in);
      chk($sformatf("tbl%0d_rf_we", i), 64'(rf_we), 64'(tbl[i].we));
      if (tbl[i].we) begin
        chk($sformatf("tbl%0d_rf_ad", i), 64'(rf_ad), 64'(tbl[i].ad));
        chk($sformatf("tbl%0d_rf_wd", i), 64'(rf_wd), 64'(tbl[i].wd));
      end
      chk($sformatf("tbl%0d_stall", i), 64'(pipe_stall), 64'(tbl[i].stall));
      chk($sformatf("tbl%0d_ready", i), 64'(lu_ready), 64'(tbl[i].ready));
      compare_model(tbl[i].in);
      advance(tbl[i].in);
    end

`ifdef WB_SCOREBOARD_EN
    // Scoreboard: hazard on r9 lasts until the cycle after its write-back.
    for (int c = 0; c < 5; c++) begin
      v = mk(0, 0, 0, 0, c == 1, 9, 32'h99);
      v.issue_valid = (c == 0); v.issue_rd = 5'd9; v.rs1 = 5'd9;
      apply(v);
      chk($sformatf("sb_hazard_c%0d", c), 64'(hazard), 64'(c >= 1 && c <= 3));
      if (c == 3) chk("sb_write_r9", 64'({rf_we, rf_ad}), 64'({1'b1, 5'd9}));
      compare_model(v);
      advance(v);
    end
    // Re-issue of r9 in the cycle its old value drains keeps it busy.
    for (int c = 0; c < 5; c++) begin
      v = mk(0, 0, 0, 0, c == 1, 9, 32'h98);
      v.issue_valid = (c == 0 || c == 3); v.issue_rd = 5'd9;
      v.rs1 = (c == 4) ? 5'd0 : 5'd9; v.rs2 = (c == 4) ? 5'd9 : 5'd0;
      apply(v);
      if (c >= 1) chk($sformatf("sb_reissue_c%0d", c), 64'(hazard), 64'(1));
      compare_model(v);
      advance(v);
    end
    v = mk(0, 0, 0, 0, 0, 0, 0);
    v.issue_valid = 1'b1; v.issue_rd = 5'd0;
    step(v);
    apply(v);
    chk("sb_r0_never", 64'(hazard), 64'(0));
    compare_model(v);
    advance(v);
`endif

    // Reset mid-operation: buffered r9 result and busy bit are discarded.
    for (int c = 0; c < 6; c++) begin
      v = mk(c == 2, c < 3, c + 1, 32'hB0 + c, c < 3, 9, 32'h99);
      v.issue_valid = (c == 0); v.issue_rd = 5'd9; v.rs1 = 5'd9;
      apply(v);
      if (c == 1) chk("mid_full_ready", 64'(lu_ready), 64'(0));
      if (c == 2) chk("mid_rst_ready", 64'(lu_ready), 64'(0));
      if (c >= 3) begin
        chk($sformatf("mid_rf_we_c%0d", c), 64'(rf_we), 64'(0));
        chk($sformatf("mid_hazard_c%0d", c), 64'(hazard), 64'(0));
        chk($sformatf("mid_ready_c%0d", c), 64'(lu_ready), 64'(1));
      end
      compare_model(v);
      advance(v);
    end

    // Random traffic against the reference model.
    for (int n = 0; n < 1500; n++) begin
      v.rst         = ($urandom_range(0, 79) == 0);
      v.pipe_we     = ($urandom_range(0, 9) < 7);
      v.pipe_rd     = AW'($urandom_range(0, 31));
      v.pipe_wd     = $urandom;
      v.lu_valid    = ($urandom_range(0, 2) == 0);
      v.lu_rd       = AW'($urandom_range(0, 7));
      v.lu_wd       = $urandom;
      v.issue_valid = ($urandom_range(0, 3) == 0);
      v.issue_rd    = AW'($urandom_range(0, 7));
      v.rs1         = AW'($urandom_range(0, 7));
      v.rs2         = AW'($urandom_range(0, 7));
      step(v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and scoreboard in front of the register file's single write port (address/enable/data). Shares that port between the in-order pipeline write-back and a long-latency unit (divider/load miss). Holds long-unit results in a one-entry buffer, bounds their wait with a starvation counter, and tracks pending destination registers so decode can stall on RAW hazards.

## Interface
- ADDRESS_WIDTH, 5, register index width; DEPTH = 1 << ADDRESS_WIDTH
- DATA_WIDTH, 32, register data width
- STARVE_LIMIT, 4, cycles a buffered long-unit result may wait before forcing a pipeline stall (≥1)

- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- pipe_we  in  1  pipeline write-back request this cycle (no handshake)
- pipe_rd  in  ADDRESS_WIDTH  pipeline destination register
- pipe_wd  in  DATA_WIDTH  pipeline write data
- pipe_stall  out  1  pipeline must hold; pipe_we this cycle is not accepted
- lu_valid  in  1  long-unit result valid
- lu_ready  out  1  arbiter can accept a long-unit result
- lu_rd  in  ADDRESS_WIDTH  long-unit destination register
- lu_wd  in  DATA_WIDTH  long-unit result data
- issue_valid  in  1  long-latency op issued this cycle (scoreboard set)
- issue_rd  in  ADDRESS_WIDTH  destination of issued op
- rs1, rs2  in  ADDRESS_WIDTH  source registers of instruction in decode
- hazard  out  1  rs1 or rs2 has a pending long-unit write
- rf_we  out  1  register file write enable (registered)
- rf_ad  out  ADDRESS_WIDTH  register file write address (registered)
- rf_wd  out  DATA_WIDTH  register file write data (registered)

## Operation
- Buffer: one entry {rd, wd}; lu_ready = !buf_full && !rst. Accept on lu_valid && lu_ready.
- Per-cycle grant (combinational): force = buf_full && (starve_cnt == STARVE_LIMIT). pipe_stall = force.
  - force: buffer wins; pipeline request ignored.
  - else pipe_we: pipeline wins; buffer waits, starve_cnt += 1 if buf_full.
  - else buf_full: buffer wins.
  - else: no write.
- Buffer win: entry drains into output stage, buf_full clears, starve_cnt ← 0. A new lu handshake in the same cycle is not possible (lu_ready low while full).
- Output stage registers winner: rf_we ← 1 if winner exists and winner rd ≠ 0; rf_ad/rf_wd ← winner fields. rd = 0 writes are consumed (handshake/grant completes) but rf_we stays 0.
- Scoreboard: busy[DEPTH] bits. Set busy[issue_rd] on issue_valid, issue_rd ≠ 0. Clear busy[rf_ad] at the edge ending a cycle where rf_we = 1 and the output stage holds a long-unit result. Set and clear of same index in one cycle: set wins.
- hazard = (rs1 ≠ 0 && busy[rs1]) || (rs2 ≠ 0 && busy[rs2]); combinational.
- Pipeline writes never touch the scoreboard.

## Timing
- Reset: rf_we 0, rf_ad 0, rf_wd 0, pipe_stall 0, lu_ready 0, hazard 0; buffer empty, starve_cnt 0, all busy bits 0. Reset mid-operation discards buffered result and pending busy bits.
- Latency: request granted in cycle N → rf_we high in cycle N+1 → register file updated at end of N+1.
- Long-unit result accepted in cycle N, pipeline idle in N+1 → rf_we in N+2.
- Max wait of a buffered result: STARVE_LIMIT cycles of pipeline writes, then one forced-stall cycle.
- busy bit clears at same edge the register file captures the value; hazard drops the following cycle, when async read returns new data.

## Configuration
- WB_SCOREBOARD_EN defined: busy array, issue_valid/issue_rd, rs1/rs2 logic present as above.
- Not defined: no busy storage; hazard tied 0; issue_valid, issue_rd, rs1, rs2 ignored. Arbitration, buffer and starvation logic unchanged.

## Test plan
- Reset: hold rst 2 cycles with lu_valid=1, pipe_we=1 → all outputs 0, lu_ready 0; first cycle after release lu_ready 1, no rf_we.
- Pipeline only: pipe_we=1, rd=5, wd=0xDEADBEEF in cycle N → rf_we=1, rf_ad=5, rf_wd=0xDEADBEEF in N+1; rd=0 → rf_we 0.
- Contention: lu result rd=7, wd=0x11 buffered while pipe_we=1 every cycle, STARVE_LIMIT=4 → 4 pipeline writes, then pipe_stall=1 one cycle, rf_ad=7, rf_wd=0x11 next cycle, lu_ready returns 1.
- Idle drain: buffer rd=3, pipe_we=0 → write to r3 one cycle after accept+1, starve_cnt stays 0, no stall.
- Scoreboard (WB_SCOREBOARD_EN): issue_valid rd=9, rs1=9 → hazard 1 until cycle after rf_we for r9; rs1=0 never hazards; issue r9 same cycle r9 drains → busy stays set.
- Reset mid-operation: buffer full, busy[9]=1, assert rst → buffer empty, hazard 0, no rf_we afterwards.
